clock_group_reset_sequencer: RTL and testbench
==============================================

// Module: clock_group_reset_sequencer
// PURPOSE
// - Sequences reset (and optionally clock enable) for the members of one clock group, e.g. subsystem_cbus_0..N-1.
// - Sits between the clock-group aggregator outputs and the member domains.
// - Holds selected members in reset for a fixed time, then releases them one at a time in ascending index order.
// - Handles power-on boot and software-requested re-reset of any member subset.
// PARAMETERS
// - NUM_MEMBERS  4   number of clock-group members sequenced (1..16)
// - HOLD_CYCLES  16  cycles all masked resets stay asserted before the first release (>=1)
// - GAP_CYCLES   4   cycles between successive member releases (>=1)
// - CNT_W        8   counter width; must hold max(HOLD_CYCLES, GAP_CYCLES)
// PORTS
// - clock                  in   1    block clock (group reference clock)
// - reset                  in   1    asynchronous, active-high reset
// - io_req_valid           in   1    re-reset request
// - io_req_ready           out  1    high only in IDLE
// - io_req_mask            in   N    members to re-reset; sampled on valid&&ready
// - io_done                out  1    one-cycle pulse when a sequence completes
// - io_busy                out  1    high in every state except IDLE
// - io_state               out  3    current FSM state encoding (debug)
// - auto_out_member_reset  out  N    per-member reset, active-high
// - auto_out_member_clk_en out  N    per-member clock enable
// BEHAVIOUR
// - Reset values:
//   - member_reset = all 1s; clk_en = all 1s; state = HOLD; active mask = all 1s (boot sequence).
//   - counter = 0; io_done = 0; io_req_ready = 0.
// - States (io_state encoding): IDLE=0, GATE_A=1, HOLD=2, GATE_R=3, RELEASE=4, GAP=5, DONE=6.
// - IDLE:
//   - ready=1. On valid&&ready with mask!=0: latch mask, assert reset of masked members next cycle, go GATE_A.
//   - mask==0 accepted: go DONE directly, no output change.
// - GATE_A: 2 cycles (feature on) or 0 cycles (feature off, skipped), then HOLD.
// - HOLD: count HOLD_CYCLES cycles, then GATE_R.
// - GATE_R: 2 cycles (feature on) or skipped (feature off), then RELEASE.
// - RELEASE: deassert reset of the lowest set bit in active mask, clear that bit.
//   - Remaining mask !=0: go GAP.
//   - Remaining mask ==0: go DONE.
// - GAP: count GAP_CYCLES cycles, then RELEASE.
// - DONE: io_done=1 for exactly one cycle, then IDLE.
// - Unmasked members: reset and clk_en never change during a sequence.
// - Requests outside IDLE: ready=0; valid is ignored and not queued; requester holds valid.
// - Latency, mask with k bits, feature off:
//   - accept to first release = 1+HOLD_CYCLES cycles;
//   - each further release +GAP_CYCLES+1;
//   - done one cycle after the last release.
// - Counter compares against parameter-1 and clears on every state change; no wrap is possible.
// - Async reset asserted mid-sequence: all members re-enter reset immediately; boot sequence restarts on deassertion.
// - Resets are registered outputs (glitch-free); deassertion is synchronous to clock.
// CONFIGURATION
// - CLOCK_GROUP_SEQ_CLKGATE_EN defined:
//   - masked members get clk_en=0 during GATE_A and GATE_R (2 cycles each) and 1 elsewhere;
//   - reset edges therefore occur only while the member clock is gated.
// - CLOCK_GROUP_SEQ_CLKGATE_EN undefined:
//   - GATE_A/GATE_R are never entered;
//   - auto_out_member_clk_en is tied to all 1s.
// TESTING
// - Boot: N=4, HOLD=16, GAP=4, feature off; release reset ->
//   - resets drop bit0 at cycle 16, bit1 at 21, bit2 at 26, bit3 at 31;
//   - io_done pulses at cycle 32.
// - Re-reset mask=4'b1010 in IDLE ->
//   - bits1,3 assert next cycle; bit1 drops 17 cycles after accept, bit3 5 cycles later;
//   - bits0,2 stay 0 throughout.
// - mask=0 accepted -> io_done pulses next cycle; no reset or clk_en toggles; ready returns 1 after.
// - valid held high during busy -> ready stays 0; request is accepted on the first IDLE cycle, at most once.
// - Async reset pulsed mid-GAP -> all resets go 1 within the same cycle; full boot sequence re-runs.
// - Feature on, mask=4'b0001 -> clk_en[0] low 2 cycles before HOLD and 2 cycles before release; reset[0] never toggles with clk_en[0]=1.

Source files
------------

// File: rtl/clock_group_reset_sequencer.sv
// clock_group_reset_sequencer
// Drives the per-member resets of one clock group. Selected members are held
// in reset for HOLD_CYCLES, then released one at a time in ascending index
// order, with GAP_CYCLES between releases. Power-on runs a boot sequence over
// all members; software can later re-reset any subset through io_req_*.
// Optional feature: define CLOCK_GROUP_SEQ_CLKGATE_EN to gate the clocks of the
// masked members for two cycles around the reset assert and release points.
// Without it the gating states are never entered and clk_en is tied high.
module clock_group_reset_sequencer #(
    parameter int NUM_MEMBERS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   io_req_valid,
    output logic                   io_req_ready,
    input  logic [NUM_MEMBERS-1:0] io_req_mask,
    output logic                   io_done,
    output logic                   io_busy,
    output logic [2:0]             io_state,
    output logic [NUM_MEMBERS-1:0] auto_out_member_reset,
    output logic [NUM_MEMBERS-1:0] auto_out_member_clk_en
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_GATE_A  = 3'd1,
        S_HOLD    = 3'd2,
        S_GATE_R  = 3'd3,
        S_RELEASE = 3'd4,
        S_GAP     = 3'd5,
        S_DONE    = 3'd6
    } state_t;

`ifdef CLOCK_GROUP_SEQ_CLKGATE_EN
    localparam bit GATE_EN = 1'b1;
`else
    localparam bit GATE_EN = 1'b0;
`endif

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0] GATE_LAST = CNT_W'(1);

    state_t                   state;
    state_t                   state_next;
    logic [CNT_W-1:0]         cnt;
    logic                     counting;
    logic                     accept;
    logic [NUM_MEMBERS-1:0]   active_mask;
    logic [NUM_MEMBERS-1:0]   member_rst_q;
    logic [NUM_MEMBERS-1:0]   lowest_bit;

    assign accept     = io_req_valid && (state == S_IDLE);
    assign lowest_bit = active_mask & (~active_mask + NUM_MEMBERS'(1));
    assign counting   = (state == S_HOLD) || (state == S_GAP) ||
                        (state == S_GATE_A) || (state == S_GATE_R);

    // State register and dwell counter; the counter restarts on every state change
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state <= S_HOLD;
            cnt   <= '0;
        end else begin
            state <= state_next;
            if (state_next != state)
                cnt <= '0;
            else if (counting)
                cnt <= cnt + CNT_W'(1);
        end
    end

    // Next-state decode: dwell states leave when the counter hits its last cycle
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (io_req_mask == '0)
                        state_next = S_DONE;
                    else
                        state_next = GATE_EN ? S_GATE_A : S_HOLD;
                end
            end
            S_GATE_A:  if (cnt == GATE_LAST) state_next = S_HOLD;
            S_HOLD:    if (cnt == HOLD_LAST) state_next = GATE_EN ? S_GATE_R : S_RELEASE;
            S_GATE_R:  if (cnt == GATE_LAST) state_next = S_RELEASE;
            S_RELEASE: state_next = (active_mask != '0) ? S_GAP : S_DONE;
            S_GAP:     if (cnt == GAP_LAST) state_next = S_RELEASE;
            S_DONE:    state_next = S_IDLE;
            default:   state_next = S_IDLE;
        endcase
    end

    // Member resets: set on accept, cleared lowest-first as each release is entered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active_mask  <= '1;
            member_rst_q <= '1;
        end else if (accept && (io_req_mask != '0)) begin
            active_mask  <= io_req_mask;
            member_rst_q <= member_rst_q | io_req_mask;
        end else if (state_next == S_RELEASE) begin
            active_mask  <= active_mask & ~lowest_bit;
            member_rst_q <= member_rst_q & ~lowest_bit;
        end
    end

    assign auto_out_member_reset = member_rst_q;

`ifdef CLOCK_GROUP_SEQ_CLKGATE_EN
    logic [NUM_MEMBERS-1:0] gate_mask;
    logic [NUM_MEMBERS-1:0] clk_en_q;

    assign gate_mask = (state == S_IDLE) ? io_req_mask : active_mask;

    // Clock enables drop for the masked members exactly while in a gating state
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            clk_en_q <= '1;
        else if ((state_next == S_GATE_A) || (state_next == S_GATE_R))
            clk_en_q <= ~gate_mask;
        else
            clk_en_q <= '1;
    end

    assign auto_out_member_clk_en = clk_en_q;
`else
    assign auto_out_member_clk_en = '1;
`endif

    // Status outputs decoded from the current state
    always_comb begin
        io_req_ready = (state == S_IDLE);
        io_busy      = (state != S_IDLE);
        io_done      = (state == S_DONE);
        io_state     = state;
    end

endmodule

// File: tb/tb_clock_group_reset_sequencer.sv
// Directed bench for clock_group_reset_sequencer (N=4, HOLD=16, GAP=4).
// Expected timings are hand-computed; the clock-gating offsets are added when
// CLOCK_GROUP_SEQ_CLKGATE_EN is defined.
module tb_clock_group_reset_sequencer;

    localparam int N    = 4;
    localparam int HOLD = 16;
    localparam int GAP  = 4;
`ifdef CLOCK_GROUP_SEQ_CLKGATE_EN
    localparam int GA = 2;
    localparam int GR = 2;
`else
    localparam int GA = 0;
    localparam int GR = 0;
`endif
    // cycles from the accept edge to the first release
    localparam int L = 1 + GA + HOLD + GR;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic         io_req_valid = 1'b0;
    logic         io_req_ready;
    logic [N-1:0] io_req_mask = '0;
    logic         io_done;
    logic         io_busy;
    logic [2:0]   io_state;
    logic [N-1:0] member_reset;
    logic [N-1:0] member_clk_en;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clock = ~clock;

    clock_group_reset_sequencer #(
        .NUM_MEMBERS(N),
        .HOLD_CYCLES(HOLD),
        .GAP_CYCLES (GAP),
        .CNT_W      (8)
    ) dut (
        .clock                 (clock),
        .reset                 (reset),
        .io_req_valid          (io_req_valid),
        .io_req_ready          (io_req_ready),
        .io_req_mask           (io_req_mask),
        .io_done               (io_done),
        .io_busy               (io_busy),
        .io_state              (io_state),
        .auto_out_member_reset (member_reset),
        .auto_out_member_clk_en(member_clk_en)
    );

    // Gating window of a sequence whose first post-accept cycle is s
    function automatic bit in_gate(input int k, input int s);
        return ((k >= s) && (k < s + GA)) ||
               ((k >= s + GA + HOLD) && (k < s + GA + HOLD + GR));
    endfunction

    // Checks the boot sequence starting at cycle 0 (reset just released)
    task automatic check_boot_sequence(input string tag);
        int           drop[N];
        logic [N-1:0] exp_rst;
        logic [N-1:0] exp_en;
        drop = '{16 + GR, 21 + GR, 26 + GR, 31 + GR};
        for (int cyc = 0; cyc <= 34 + GR; cyc++) begin
            if (cyc > 0) begin
                @(posedge clock);
                #1;
            end else begin
                #1;
            end
            for (int i = 0; i < N; i++)
                exp_rst[i] = (cyc < drop[i]);
            exp_en = ((cyc >= HOLD) && (cyc < HOLD + GR)) ? '0 : '1;
            n_compared++;
            if (member_reset !== exp_rst) begin
                n_mismatched++;
                $display("[TB] FAIL %s reset cyc=%0d got=%b want=%b", tag, cyc, member_reset, exp_rst);
            end
            n_compared++;
            if (member_clk_en !== exp_en) begin
                n_mismatched++;
                $display("[TB] FAIL %s clk_en cyc=%0d got=%b want=%b", tag, cyc, member_clk_en, exp_en);
            end
            n_compared++;
            if (io_done !== (cyc == 32 + GR)) begin
                n_mismatched++;
                $display("[TB] FAIL %s done cyc=%0d got=%b want=%b", tag, cyc, io_done, (cyc == 32 + GR));
            end
            n_compared++;
            if (io_req_ready !== (cyc >= 33 + GR)) begin
                n_mismatched++;
                $display("[TB] FAIL %s ready cyc=%0d got=%b want=%b", tag, cyc, io_req_ready, (cyc >= 33 + GR));
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        n_compared++;
        if (member_reset !== 4'b1111) begin
            n_mismatched++;
            $display("[TB] FAIL reset_rst got=%b want=1111", member_reset);
        end
        n_compared++;
        if (member_clk_en !== 4'b1111) begin
            n_mismatched++;
            $display("[TB] FAIL reset_clk_en got=%b want=1111", member_clk_en);
        end
        n_compared++;
        if (io_state !== 3'd2) begin
            n_mismatched++;
            $display("[TB] FAIL reset_state got=%0d want=2", io_state);
        end
        n_compared++;
        if ({io_req_ready, io_done, io_busy} !== 3'b001) begin
            n_mismatched++;
            $display("[TB] FAIL reset_flags got=%b want=001", {io_req_ready, io_done, io_busy});
        end
    endtask

    task automatic test_boot();
        @(negedge clock);
        reset = 1'b0;
        check_boot_sequence("boot");
    endtask

    task automatic test_rereset();
        int           rel1;
        int           rel3;
        int           dn;
        logic [N-1:0] exp_rst;
        logic [N-1:0] exp_en;
        rel1 = L;
        rel3 = rel1 + GAP + 1;
        dn   = rel3 + 1;
        @(negedge clock);
        io_req_valid = 1'b1;
        io_req_mask  = 4'b1010;
        for (int k = 1; k <= dn + 2; k++) begin
            @(posedge clock);
            #1;
            exp_rst = {(k < rel3), 1'b0, (k < rel1), 1'b0};
            exp_en  = in_gate(k, 1) ? 4'b0101 : 4'b1111;
            n_compared++;
            if (member_reset !== exp_rst) begin
                n_mismatched++;
                $display("[TB] FAIL rereset reset k=%0d got=%b want=%b", k, member_reset, exp_rst);
            end
            n_compared++;
            if (member_clk_en !== exp_en) begin
                n_mismatched++;
                $display("[TB] FAIL rereset clk_en k=%0d got=%b want=%b", k, member_clk_en, exp_en);
            end
            n_compared++;
            if (io_done !== (k == dn)) begin
                n_mismatched++;
                $display("[TB] FAIL rereset done k=%0d got=%b want=%b", k, io_done, (k == dn));
            end
            n_compared++;
            if (io_busy !== (k <= dn)) begin
                n_mismatched++;
                $display("[TB] FAIL rereset busy k=%0d got=%b want=%b", k, io_busy, (k <= dn));
            end
            if (k == 1) begin
                io_req_valid = 1'b0;
                io_req_mask  = '0;
            end
        end
    endtask

    task automatic test_zero_mask();
        @(negedge clock);
        io_req_valid = 1'b1;
        io_req_mask  = 4'b0000;
        @(posedge clock);
        #1;
        io_req_valid = 1'b0;
        n_compared++;
        if (io_state !== 3'd6 || io_done !== 1'b1 || io_req_ready !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL zero_mask_first state/done/ready got=%0d/%b/%b want=6/1/0", io_state, io_done, io_req_ready);
        end
        n_compared++;
        if (member_reset !== 4'b0000 || member_clk_en !== 4'b1111) begin
            n_mismatched++;
            $display("[TB] FAIL zero_mask_first rst/en got=%b/%b want=0000/1111", member_reset, member_clk_en);
        end
        @(posedge clock);
        #1;
        n_compared++;
        if (io_state !== 3'd0 || io_done !== 1'b0 || io_req_ready !== 1'b1) begin
            n_mismatched++;
            $display("[TB] FAIL zero_mask_after state/done/ready got=%0d/%b/%b want=0/0/1", io_state, io_done, io_req_ready);
        end
        n_compared++;
        if (member_reset !== 4'b0000 || member_clk_en !== 4'b1111) begin
            n_mismatched++;
            $display("[TB] FAIL zero_mask_after rst/en got=%b/%b want=0000/1111", member_reset, member_clk_en);
        end
    endtask

    task automatic test_back_to_back();
        int           s2;
        logic [N-1:0] exp_rst;
        logic [N-1:0] exp_en;
        bit           exp_busy;
        s2 = L + 3;
        @(negedge clock);
        io_req_valid = 1'b1;
        io_req_mask  = 4'b0100;
        for (int k = 1; k <= 2 * L + 8; k++) begin
            @(posedge clock);
            #1;
            exp_rst  = '0;
            exp_rst[2] = ((k >= 1) && (k < L)) || ((k >= s2) && (k < s2 + L - 1));
            exp_en   = (in_gate(k, 1) || in_gate(k, s2)) ? 4'b1011 : 4'b1111;
            exp_busy = !((k == L + 2) || (k >= 2 * L + 4));
            n_compared++;
            if (member_reset !== exp_rst) begin
                n_mismatched++;
                $display("[TB] FAIL b2b reset k=%0d got=%b want=%b", k, member_reset, exp_rst);
            end
            n_compared++;
            if (member_clk_en !== exp_en) begin
                n_mismatched++;
                $display("[TB] FAIL b2b clk_en k=%0d got=%b want=%b", k, member_clk_en, exp_en);
            end
            n_compared++;
            if (io_req_ready !== !exp_busy) begin
                n_mismatched++;
                $display("[TB] FAIL b2b ready k=%0d got=%b want=%b", k, io_req_ready, !exp_busy);
            end
            n_compared++;
            if (io_done !== ((k == L + 1) || (k == 2 * L + 3))) begin
                n_mismatched++;
                $display("[TB] FAIL b2b done k=%0d got=%b want=%b", k, io_done, ((k == L + 1) || (k == 2 * L + 3)));
            end
            if (k == s2) begin
                io_req_valid = 1'b0;
                io_req_mask  = '0;
            end
        end
    endtask

    task automatic test_async_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int c = 1; c <= 18 + GR; c++) begin
            @(posedge clock);
            #1;
        end
        n_compared++;
        if (io_state !== 3'd5 || member_reset !== 4'b1110) begin
            n_mismatched++;
            $display("[TB] FAIL async_pre state/rst got=%0d/%b want=5/1110", io_state, member_reset);
        end
        #2;
        reset = 1'b1;
        #1;
        n_compared++;
        if (member_reset !== 4'b1111 || member_clk_en !== 4'b1111) begin
            n_mismatched++;
            $display("[TB] FAIL async_now rst/en got=%b/%b want=1111/1111", member_reset, member_clk_en);
        end
        n_compared++;
        if (io_state !== 3'd2) begin
            n_mismatched++;
            $display("[TB] FAIL async_now state got=%0d want=2", io_state);
        end
        @(negedge clock);
        reset = 1'b0;
        check_boot_sequence("reboot");
    endtask

`ifdef CLOCK_GROUP_SEQ_CLKGATE_EN
    task automatic test_clkgate();
        logic prev_rst;
        logic prev_en;
        bit   exp_en0;
        prev_rst = member_reset[0];
        prev_en  = member_clk_en[0];
        @(negedge clock);
        io_req_valid = 1'b1;
        io_req_mask  = 4'b0001;
        for (int k = 1; k <= L + 3; k++) begin
            @(posedge clock);
            #1;
            io_req_valid = 1'b0;
            exp_en0 = !in_gate(k, 1);
            n_compared++;
            if (member_clk_en[0] !== exp_en0) begin
                n_mismatched++;
                $display("[TB] FAIL clkgate en0 k=%0d got=%b want=%b", k, member_clk_en[0], exp_en0);
            end
            if (member_reset[0] !== prev_rst) begin
                n_compared++;
                if (prev_en !== 1'b0 && member_clk_en[0] !== 1'b0) begin
                    n_mismatched++;
                    $display("[TB] FAIL clkgate ungated_edge k=%0d en_prev=%b en=%b want a 0", k, prev_en, member_clk_en[0]);
                end
            end
            prev_rst = member_reset[0];
            prev_en  = member_clk_en[0];
        end
    endtask
`endif

    initial begin
        test_reset();
        test_boot();
        test_rereset();
        test_zero_mask();
        test_back_to_back();
        test_async_reset();
`ifdef CLOCK_GROUP_SEQ_CLKGATE_EN
        test_clkgate();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

endmodule
